// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: FSM states, halt opcode,
// PC step, NOP encoding and the PC increment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [3:0]  HLT_OPC = 4'hF;
  localparam logic [15:0] PC_INC  = 16'd2;
  localparam logic [15:0] NOP     = 16'h0000;

  function automatic logic [15:0] pc_next(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Holding register for one fetched instruction and its PC while the ID stage
// is frozen. Clear takes priority over load.
module fetch_buf (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_clr,
  input  logic [15:0] i_inst,
  input  logic [15:0] i_pc,
  output logic [15:0] o_inst,
  output logic [15:0] o_pc
);
  import cpu_pkg::*;

  logic [15:0] r_inst;
  logic [15:0] r_pc;

  // Buffer update: clear on reset or redirect, capture on load, else hold.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_inst <= NOP;
      r_pc   <= 16'h0000;
    end else if (i_load) begin
      r_inst <= i_inst;
      r_pc   <= i_pc;
    end else begin
      r_inst <= r_inst;
      r_pc   <= r_pc;
    end
  end

  assign o_inst = r_inst;
  assign o_pc   = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, freeze hold,
// branch redirect and HLT stop. Define FETCH_STALL_CNT_EN to enable stall_cnt_o.
module fetch_unit #(
  parameter logic [15:0] RST_PC  = 16'h0000,
  parameter logic [3:0]  HLT_OPC = cpu_pkg::HLT_OPC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_target_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [15:0] imem_data_i,
  output logic [15:0] inst_o,
  output logic [15:0] pc_o,
  output logic        if_valid_o,
  output logic        halted_o,
  output logic [15:0] stall_cnt_o
);
  import cpu_pkg::*;

  fetch_state_t r_state;
  logic [15:0]  r_pc;
  logic [15:0]  r_tgt;
  logic         r_redirect_pend;

  logic [15:0]  w_buf_inst;
  logic [15:0]  w_buf_pc;
  logic         w_req;
  logic         w_valid_raw;
  logic         w_valid;
  logic         w_is_hlt;
  logic         w_buf_load;
  logic [15:0]  w_inst;
  logic [15:0]  w_pc_cur;

  // Output source: memory word while requesting, buffered word in HOLD.
  always_comb begin
    w_req       = 1'b0;
    w_inst      = NOP;
    w_pc_cur    = r_pc;
    w_valid_raw = 1'b0;
    if (rst) begin
      w_req = 1'b0;
    end else begin
      case (r_state)
        FETCH, WAIT: begin
          w_req       = 1'b1;
          w_inst      = imem_data_i;
          w_valid_raw = imem_ready_i & ~r_redirect_pend;
        end
        HOLD: begin
          w_inst      = w_buf_inst;
          w_pc_cur    = w_buf_pc;
          w_valid_raw = 1'b1;
        end
        default: begin
          w_valid_raw = 1'b0;
        end
      endcase
    end
  end

  assign w_valid    = w_valid_raw & ~branch_taken_i;
  assign w_is_hlt   = (w_inst[15:12] == HLT_OPC);
  assign w_buf_load = w_valid & freeze_i & (r_state != HOLD);

  fetch_buf u_buf (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_buf_load),
    .i_clr  (branch_taken_i),
    .i_inst (w_inst),
    .i_pc   (r_pc),
    .o_inst (w_buf_inst),
    .o_pc   (w_buf_pc)
  );

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_pc;
  assign if_valid_o  = w_valid;
  assign inst_o      = w_valid ? w_inst : NOP;
  assign pc_o        = w_valid ? pc_next(w_pc_cur) : 16'h0000;
  assign halted_o    = ~rst & (r_state == HALTED);

  // Fetch FSM; a branch with a request in flight is parked in r_tgt until
  // the stale word returns, so imem_addr_o never moves mid-request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= FETCH;
      r_pc            <= RST_PC;
      r_tgt           <= 16'h0000;
      r_redirect_pend <= 1'b0;
    end else begin
      case (r_state)
        FETCH, WAIT: begin
          if (imem_ready_i) begin
            if (r_redirect_pend) begin
              r_pc            <= branch_taken_i ? branch_target_i : r_tgt;
              r_redirect_pend <= 1'b0;
              r_state         <= FETCH;
            end else if (branch_taken_i) begin
              r_pc    <= branch_target_i;
              r_state <= FETCH;
            end else if (freeze_i) begin
              r_state <= HOLD;
            end else if (w_is_hlt) begin
              r_state <= HALTED;
            end else begin
              r_pc    <= pc_next(r_pc);
              r_state <= FETCH;
            end
          end else begin
            if (branch_taken_i) begin
              r_tgt           <= branch_target_i;
              r_redirect_pend <= 1'b1;
            end
            r_state <= WAIT;
          end
        end
        HOLD: begin
          if (branch_taken_i) begin
            r_pc    <= branch_target_i;
            r_state <= FETCH;
          end else if (freeze_i) begin
            r_state <= HOLD;
          end else if (w_is_hlt) begin
            r_state <= HALTED;
          end else begin
            r_pc    <= pc_next(r_pc);
            r_state <= FETCH;
          end
        end
        HALTED: begin
          if (branch_taken_i) begin
            r_pc    <= branch_target_i;
            r_state <= FETCH;
          end else begin
            r_state <= HALTED;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles spent waiting on memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if ((r_state == WAIT) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt_o = rst ? 16'h0000 : r_stall_cnt;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a program-walk model predicts the consumed
// instruction stream; a memory responder supplies random latencies.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [15:0] branch_target_i = 16'h0000;
  logic        imem_ready_i = 1'b0;
  logic [15:0] imem_data_i = 16'h0000;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic [15:0] inst_o;
  logic [15:0] pc_o;
  logic        if_valid_o;
  logic        halted_o;
  logic [15:0] stall_cnt_o;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .freeze_i        (freeze_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_data_i     (imem_data_i),
    .inst_o          (inst_o),
    .pc_o            (pc_o),
    .if_valid_o      (if_valid_o),
    .halted_o        (halted_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  typedef struct packed { logic [15:0] inst; logic [15:0] pc; } exp_t;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] mem [0:255];
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  int          lat_left = 0;
  bit          busy = 1'b0;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem[a[8:1]];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instructions consumed from a start address are the
  // program walk up to and including the first HLT word.
  task automatic push_walk(input logic [15:0] start);
    logic [15:0] a;
    exp_t e;
    a = start;
    sb_q.delete();
    for (int k = 0; k < 300; k++) begin
      e.inst = mem_rd(a);
      e.pc   = a + 16'd2;
      sb_q.push_back(e);
      if (e.inst[15:12] == 4'hF) break;
      a = a + 16'd2;
    end
  endtask

  // Memory responder: random latency per request, abandons on dropped request.
  always @(posedge clk) begin
    #2;
    if (!imem_req_o) begin
      busy = 1'b0;
      imem_ready_i = 1'b0;
      imem_data_i = 16'($urandom);
    end else begin
      if (!busy) begin
        busy = 1'b1;
        lat_left = int'($urandom_range(lat_max, lat_min));
      end
      if (lat_left == 0) begin
        imem_ready_i = 1'b1;
        imem_data_i = mem_rd(imem_addr_o);
        busy = 1'b0;
      end else begin
        imem_ready_i = 1'b0;
        imem_data_i = 16'($urandom);
        lat_left--;
      end
    end
  end

  // Monitor: compare presented words against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_outputs", {imem_req_o, if_valid_o, halted_o, inst_o, pc_o, stall_cnt_o}, 64'd0);
    end else if (branch_taken_i) begin
      check("branch_kill", if_valid_o, 64'd0);
    end else if (if_valid_o) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got inst %0h pc %0h expected no output", inst_o, pc_o);
      end else begin
        mon_e = sb_q[0];
        check("inst", inst_o, mon_e.inst);
        check("pc", pc_o, mon_e.pc);
        if (!freeze_i) void'(sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; freeze_i = 1'b0; branch_taken_i = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    push_walk(16'h0000);
  endtask

  task automatic branch_to(input logic [15:0] t);
    @(posedge clk); #1;
    branch_taken_i = 1'b1;
    branch_target_i = t;
    push_walk(t);
    @(posedge clk); #1;
    branch_taken_i = 1'b0;
    branch_target_i = 16'($urandom);
  endtask

  task automatic wait_halt(input string name);
    int c;
    c = 0;
    @(negedge clk);
    while (!halted_o && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({name, "_halted"}, halted_o, 64'd1);
    check({name, "_req_off"}, imem_req_o, 64'd0);
    check({name, "_drained"}, sb_q.size(), 64'd0);
  endtask

  initial begin
    int k;
    int gap;
    bit found;
    int r;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
      if (i % 12 == 11) mem[i] = 16'hF000;
    end

    // Zero-wait stream from PC 0, then halt at the first HLT word.
    lat_min = 0; lat_max = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("zw_valid", if_valid_o, 64'd1);
      check("zw_addr", imem_addr_o, 64'(2 * i));
    end
    wait_halt("zw");

    // Resume from HALTED via branch to 0x0010.
    branch_to(16'h0010);
    @(negedge clk);
    check("resume_req", imem_req_o, 64'd1);
    check("resume_addr", imem_addr_o, 64'h0010);
    wait_halt("resume");

    // PC wrap at 0xFFFE.
    branch_to(16'hFFFE);
    @(negedge clk);
    check("wrap_addr0", imem_addr_o, 64'hFFFE);
    @(negedge clk);
    check("wrap_addr1", imem_addr_o, 64'h0000);
    wait_halt("wrap");

    // Freeze for 3 cycles on a ready word.
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    freeze_i = 1'b1;
    @(negedge clk);
    check("frz_valid0", if_valid_o, 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("frz_hold_req", imem_req_o, 64'd0);
      check("frz_hold_valid", if_valid_o, 64'd1);
    end
    @(posedge clk); #1;
    freeze_i = 1'b0;
    @(negedge clk);
    check("frz_rel_req", imem_req_o, 64'd0);
    @(negedge clk);
    check("frz_next_req", imem_req_o, 64'd1);
    check("frz_next_addr", imem_addr_o, 64'h0006);

    // 3-cycle latency: two bubbles per instruction, address held.
    lat_min = 2; lat_max = 2;
    do_reset();
    k = 0; gap = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(negedge clk);
      check("lat3_addr", imem_addr_o, 64'(2 * k));
      if (if_valid_o) begin
        if (k > 0) check("lat3_gap", gap, 64'd2);
        k++;
        gap = 0;
      end else begin
        if (k == 1 && gap == 0) begin
`ifdef FETCH_STALL_CNT_EN
          check("lat3_stall_cnt", stall_cnt_o, 64'd2);
`else
          check("lat3_stall_cnt", stall_cnt_o, 64'd0);
`endif
        end
        gap++;
      end
    end
    check("lat3_count", k, 64'd5);

    // Branch to 0x0040 while a request is outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    branch_to(16'h0040);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (imem_ready_i) begin
        found = 1'b1;
        check("stale_drop", if_valid_o, 64'd0);
        check("stale_addr", imem_addr_o, 64'h0000);
      end
    end
    check("stale_seen", found, 64'd1);
    @(negedge clk);
    check("redir_req", imem_req_o, 64'd1);
    check("redir_addr", imem_addr_o, 64'h0040);
    wait_halt("redir");

    // Randomized traffic: latency, freeze, branches and occasional resets.
    lat_min = 0; lat_max = 3;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      branch_taken_i = 1'b0;
      if (rst) begin
        rst = 1'b0;
        push_walk(16'h0000);
      end else begin
        r = int'($urandom_range(99, 0));
        freeze_i = ($urandom_range(3, 0) == 0);
        if (r < 4 || (halted_o && r < 30)) begin
          branch_taken_i = 1'b1;
          branch_target_i = 16'($urandom) & 16'hFFFE;
          push_walk(branch_target_i);
        end else if (r == 99) begin
          rst = 1'b1;
          sb_q.delete();
        end
      end
    end
    @(posedge clk); #1;
    branch_taken_i = 1'b0;
    freeze_i = 1'b0;
    if (rst) begin
      rst = 1'b0;
      push_walk(16'h0000);
    end
    wait_halt("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
